// File: rtl/cl_axi_burst_pkg.sv
// Shared definitions for the AXI4 512-bit burst initiator.
// Holds the FSM state enum, AXI size/response constants, buffer geometry
// and a helper that picks the worse of two AXI responses.
package cl_axi_burst_pkg;

  typedef enum logic [2:0] {
    IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE
  } state_e;

  localparam logic [2:0] AXI_SIZE_64B = 3'b110;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  localparam int         BUF_DEPTH    = 16;
  localparam int         DATA_W       = 512;

  // AXI response codes are ordered by severity, so "worst" is the larger one.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cl_axi_burst_buf.sv
// 16 x 512 local burst buffer.
// Ports:
//   clk, rst_n                 clock, async active-low reset (read registers only)
//   axi_we/axi_idx/axi_data    write port fed by arriving R beats (wins on index clash)
//   usr_we/usr_idx/usr_data    write port fed by CL buffer-load logic
//   pf_idx/pf_data             registered read port used to prefetch W data
//   rb_idx/rb_data             registered read port for CL readback
module cl_axi_burst_buf
  import cl_axi_burst_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              axi_we,
  input  logic [3:0]        axi_idx,
  input  logic [DATA_W-1:0] axi_data,
  input  logic              usr_we,
  input  logic [3:0]        usr_idx,
  input  logic [DATA_W-1:0] usr_data,
  input  logic [3:0]        pf_idx,
  output logic [DATA_W-1:0] pf_data,
  input  logic [3:0]        rb_idx,
  output logic [DATA_W-1:0] rb_data
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];

  // Contents are not reset. The AXI write is last so it overrides a user
  // write to the same entry in the same cycle.
  always_ff @(posedge clk) begin
    if (usr_we) mem[usr_idx] <= usr_data;
    if (axi_we) mem[axi_idx] <= axi_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_data <= '0;
      rb_data <= '0;
    end else begin
      pf_data <= mem[pf_idx];
      rb_data <= mem[rb_idx];
    end
  end

endmodule

// File: rtl/cl_axi_burst_mstr.sv
// AXI4 512-bit burst initiator: one command at a time writes 1-16 beats
// from the local buffer or reads a burst into it, then pulses done with
// the worst response seen.
// Ports: clk/rst_n; cmd_* command handshake; buf_wr_* buffer load;
//   buf_rd_idx/buf_rd_data readback (1-cycle registered); busy; done/done_resp;
//   m_axi_aw*/w*/b*/ar*/r* AXI4 master channels.
// Optional: define CL_AXI_BURST_MSTR_CMP_EN to compare each R beat against
//   the buffer entry it overwrites; adds sticky output cmp_err.
module cl_axi_burst_mstr
  import cl_axi_burst_pkg::*;
#(
  parameter int ID_W   = 6,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic              buf_wr_en,
  input  logic [3:0]        buf_wr_idx,
  input  logic [511:0]      buf_wr_data,
  input  logic [3:0]        buf_rd_idx,
  output logic [511:0]      buf_rd_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        done_resp,
`ifdef CL_AXI_BURST_MSTR_CMP_EN
  output logic              cmp_err,
`endif
  output logic [ID_W-1:0]   m_axi_awid,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [511:0]      m_axi_wdata,
  output logic [63:0]       m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [ID_W-1:0]   m_axi_bid,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [ID_W-1:0]   m_axi_rid,
  input  logic [511:0]      m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);

  state_e            state, state_nxt;
  logic [4:0]        cnt, cnt_nxt;     // one extra bit so "past len" is visible
  logic [1:0]        err_q, err_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        len_q;
  logic [ID_W-1:0]   id_q;
  logic              axi_we;
  logic              accept;
  logic              r_flag;
  logic [511:0]      pf_data;

  assign accept = (state == IDLE) && cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      err_q  <= RESP_OKAY;
      addr_q <= '0;
      len_q  <= '0;
      id_q   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
      if (accept) begin
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
        id_q   <= cmd_id;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    err_nxt       = err_q;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    done          = 1'b0;
    axi_we        = 1'b0;
    r_flag        = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cnt_nxt   = '0;
          err_nxt   = RESP_OKAY;
          state_nxt = cmd_wr ? WADDR : RADDR;
        end
      end
      WADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = WDATA;
      end
      WDATA: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready) begin
          cnt_nxt = cnt + 5'd1;
          if (m_axi_wlast) state_nxt = WRESP;
        end
      end
      WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          // ID mismatch escalates to SLVERR but never masks a DECERR.
          err_nxt = (m_axi_bid != id_q && m_axi_bresp != RESP_DECERR) ? RESP_SLVERR
                                                                       : m_axi_bresp;
          state_nxt = DONE;
        end
      end
      RADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = RDATA;
      end
      RDATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          r_flag = (m_axi_rid != id_q) ||
                   (m_axi_rlast && cnt < {1'b0, len_q}) ||
                   (!m_axi_rlast && cnt == {1'b0, len_q});
          // Beats beyond the requested length are discarded.
          if (cnt <= {1'b0, len_q}) begin
            axi_we  = 1'b1;
            cnt_nxt = cnt + 5'd1;
            err_nxt = resp_worst(err_q, m_axi_rresp);
          end
          if (r_flag) err_nxt = resp_worst(err_nxt, RESP_SLVERR);
          if (m_axi_rlast) state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Prefetching at the next count keeps buf[cnt] on pf_data every cycle of
  // WDATA/RDATA, and re-reads each cycle so a reloaded unsent beat is picked up.
  cl_axi_burst_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .axi_we   (axi_we),
    .axi_idx  (cnt[3:0]),
    .axi_data (m_axi_rdata),
    .usr_we   (buf_wr_en),
    .usr_idx  (buf_wr_idx),
    .usr_data (buf_wr_data),
    .pf_idx   (cnt_nxt[3:0]),
    .pf_data  (pf_data),
    .rb_idx   (buf_rd_idx),
    .rb_data  (buf_rd_data)
  );

`ifdef CL_AXI_BURST_MSTR_CMP_EN
  logic cmp_err_q;
  // During RDATA pf_data holds the entry's contents before this beat lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            cmp_err_q <= 1'b0;
    else if (accept)                       cmp_err_q <= 1'b0;
    else if (axi_we && m_axi_rdata != pf_data) cmp_err_q <= 1'b1;
  end
  assign cmp_err = cmp_err_q;
`endif

  assign busy          = (state != IDLE);
  assign done_resp     = err_q;
  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = {4'b0, len_q};
  assign m_axi_awsize  = AXI_SIZE_64B;
  assign m_axi_wdata   = pf_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (cnt[3:0] == len_q);
  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = {4'b0, len_q};
  assign m_axi_arsize  = AXI_SIZE_64B;

endmodule
